// File: rtl/noc2validready_handshake_adapter.sv
// Receive-side NoC ejection adapter: avail/valid flits into a first-word-fall-through FIFO,
// presented to a local consumer on a valid/ready interface.
module noc2validready_handshake_adapter #(
   parameter int unsigned FlitWidth = 64,
   parameter int unsigned Depth     = 4,
   localparam int unsigned PtrW     = $clog2(Depth),
   localparam int unsigned CntW     = $clog2(Depth) + 1
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [FlitWidth-1:0] noc_flit_i,
   input  logic                 noc_valid_i,
   output logic                 noc_avail_o,
   output logic [FlitWidth-1:0] m_data_o,
   output logic                 m_valid_o,
   input  logic                 m_ready_i,
   output logic [CntW-1:0]      occupancy_o,
   output logic                 protocol_error_o
);

   logic [FlitWidth-1:0] mem_q [Depth];
   logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]      count_q, count_d;
   logic                 avail_q, avail_d;
   logic                 err_q, err_d;

   logic push, pop, full, wr_en;

   assign push  = noc_valid_i;
   assign pop   = m_valid_o & m_ready_i;
   assign full  = (count_q == CntW'(Depth));
   // A full FIFO still accepts a flit when the head leaves in the same cycle.
   assign wr_en = push & (~full | pop);

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      err_d    = err_q;

      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrW'(1);
      end

      unique case ({wr_en, pop})
         2'b10:   count_d = count_q + CntW'(1);
         2'b01:   count_d = count_q - CntW'(1);
         default: count_d = count_q;
      endcase

      if (push && !wr_en) begin
         err_d = 1'b1;
      end

      // Keep room for a flit already in flight plus one more; pops are not credited early.
      avail_d = (count_d <= CntW'(Depth - 2));
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         avail_q  <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         avail_q  <= avail_d;
         err_q    <= err_d;
      end
   end

   // Storage array is intentionally not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= noc_flit_i;
      end
   end

   assign m_valid_o        = (count_q != '0);
   assign m_data_o         = mem_q[rd_ptr_q];
   assign noc_avail_o      = avail_q;
   assign occupancy_o      = count_q;
   assign protocol_error_o = err_q;

endmodule

// File: tb/tb_noc2validready_handshake_adapter.sv
// Self-checking bench: directed vector table, streaming, reset corners, and
// randomized traffic against a queue-based reference model.
module tb_noc2validready_handshake_adapter;

   localparam int unsigned FW    = 64;
   localparam int unsigned Depth = 4;
   localparam int unsigned CntW  = $clog2(Depth) + 1;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic [FW-1:0]   noc_flit_i;
   logic            noc_valid_i;
   logic            noc_avail_o;
   logic [FW-1:0]   m_data_o;
   logic            m_valid_o;
   logic            m_ready_i;
   logic [CntW-1:0] occupancy_o;
   logic            protocol_error_o;

   noc2validready_handshake_adapter #(
      .FlitWidth(FW),
      .Depth    (Depth)
   ) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .noc_flit_i      (noc_flit_i),
      .noc_valid_i     (noc_valid_i),
      .noc_avail_o     (noc_avail_o),
      .m_data_o        (m_data_o),
      .m_valid_o       (m_valid_o),
      .m_ready_i       (m_ready_i),
      .occupancy_o     (occupancy_o),
      .protocol_error_o(protocol_error_o)
   );

   always #5 clk_i = ~clk_i;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: the FIFO contents as a queue, plus avail and sticky error.
   logic [FW-1:0] mq[$];
   logic          m_avail;
   logic          m_err;

   typedef struct {
      logic          v;
      logic [FW-1:0] f;
      logic          r;
      logic          ev;
      logic [FW-1:0] ed;
      int            eo;
      logic          ea;
      logic          ee;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_avail = 1'b0;
      m_err   = 1'b0;
   endtask

   task automatic model_edge();
      if (mq.size() != 0 && m_ready_i) void'(mq.pop_front());
      if (noc_valid_i) begin
         if (mq.size() < Depth) mq.push_back(noc_flit_i);
         else m_err = 1'b1;
      end
      m_avail = (mq.size() <= Depth - 2);
   endtask

   task automatic check_model(input string tag);
      check({tag, ".m_valid"}, 64'(m_valid_o), 64'(mq.size() != 0));
      if (mq.size() != 0) check({tag, ".m_data"}, m_data_o, mq[0]);
      check({tag, ".occupancy"}, 64'(occupancy_o), 64'(mq.size()));
      check({tag, ".avail"}, 64'(noc_avail_o), 64'(m_avail));
      check({tag, ".err"}, 64'(protocol_error_o), 64'(m_err));
   endtask

   task automatic tick(input logic v, input logic [FW-1:0] f, input logic r);
      noc_valid_i = v;
      noc_flit_i  = f;
      m_ready_i   = r;
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, ".avail"}, 64'(noc_avail_o), 64'(0));
      check({tag, ".m_valid"}, 64'(m_valid_o), 64'(0));
      check({tag, ".occupancy"}, 64'(occupancy_o), 64'(0));
      check({tag, ".err"}, 64'(protocol_error_o), 64'(0));
   endtask

   task automatic do_reset();
      rst_ni      = 1'b0;
      noc_valid_i = 1'b0;
      noc_flit_i  = '0;
      m_ready_i   = 1'b0;
      model_reset();
      repeat (3) begin
         @(posedge clk_i);
         #1;
         check_reset_outputs("reset");
      end
      rst_ni = 1'b1;
      #1;
      check("release.avail_before_edge", 64'(noc_avail_o), 64'(0));
      tick(1'b0, '0, 1'b0);
      check("release.avail_after_edge", 64'(noc_avail_o), 64'(1));
      check_model("release");
   endtask

   initial begin
      // Depth=4 directed sequence: fill, stall, drain, full push+pop with wrap, overflow.
      tbl[0]  = '{1'b1, 64'hA1,   1'b0, 1'b1, 64'hA1, 1, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 64'hA2,   1'b0, 1'b1, 64'hA1, 2, 1'b1, 1'b0};
      tbl[2]  = '{1'b1, 64'hA3,   1'b0, 1'b1, 64'hA1, 3, 1'b0, 1'b0};
      tbl[3]  = '{1'b1, 64'hA4,   1'b0, 1'b1, 64'hA1, 4, 1'b0, 1'b0};
      tbl[4]  = '{1'b0, 64'h0,    1'b0, 1'b1, 64'hA1, 4, 1'b0, 1'b0};
      tbl[5]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hA2, 3, 1'b0, 1'b0};
      tbl[6]  = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hA3, 2, 1'b1, 1'b0};
      tbl[7]  = '{1'b1, 64'hB1,   1'b1, 1'b1, 64'hA4, 2, 1'b1, 1'b0};
      tbl[8]  = '{1'b1, 64'hB2,   1'b0, 1'b1, 64'hA4, 3, 1'b0, 1'b0};
      tbl[9]  = '{1'b1, 64'hB3,   1'b0, 1'b1, 64'hA4, 4, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 64'hB4,   1'b1, 1'b1, 64'hB1, 4, 1'b0, 1'b0};
      tbl[11] = '{1'b1, 64'hDEAD, 1'b0, 1'b1, 64'hB1, 4, 1'b0, 1'b1};
      tbl[12] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hB2, 3, 1'b0, 1'b1};
      tbl[13] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hB3, 2, 1'b1, 1'b1};
      tbl[14] = '{1'b0, 64'h0,    1'b1, 1'b1, 64'hB4, 1, 1'b1, 1'b1};
      tbl[15] = '{1'b0, 64'h0,    1'b1, 1'b0, 64'h0,  0, 1'b1, 1'b1};

      do_reset();

      for (int i = 0; i < 16; i++) begin
         tick(tbl[i].v, tbl[i].f, tbl[i].r);
         check($sformatf("vec%0d.m_valid", i), 64'(m_valid_o), 64'(tbl[i].ev));
         if (tbl[i].ev) check($sformatf("vec%0d.m_data", i), m_data_o, tbl[i].ed);
         check($sformatf("vec%0d.occupancy", i), 64'(occupancy_o), 64'(tbl[i].eo));
         check($sformatf("vec%0d.avail", i), 64'(noc_avail_o), 64'(tbl[i].ea));
         check($sformatf("vec%0d.err", i), 64'(protocol_error_o), 64'(tbl[i].ee));
      end

      // Streaming at one flit per cycle: each flit visible the cycle after it is sent.
      do_reset();
      for (int i = 1; i <= 32; i++) begin
         tick(1'b1, 64'(i), 1'b1);
         check($sformatf("stream%0d.data", i), m_data_o, 64'(i));
         check($sformatf("stream%0d.avail", i), 64'(noc_avail_o), 64'(1));
         check_model("stream");
      end
      tick(1'b0, '0, 1'b1);
      check_model("stream_end");

      // Asynchronous reset in the middle of a cycle with flits buffered.
      for (int i = 0; i < 3; i++) begin
         tick(1'b1, 64'(16'hC0 + i), 1'b0);
         check_model("pre_reset");
      end
      #3;
      rst_ni = 1'b0;
      #1;
      check_reset_outputs("async_reset");
      model_reset();
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      tick(1'b0, '0, 1'b1);
      check_model("post_async_reset");
      tick(1'b0, '0, 1'b1);
      check("post_async_reset.no_stale", 64'(m_valid_o), 64'(0));

      // Randomized traffic; sender obeys avail, with rare violations late in the run.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         logic v, r;
         r = ($urandom_range(0, 9) < 7);
         if (m_avail) v = ($urandom_range(0, 9) < 6);
         else v = (i >= 1500) && ($urandom_range(0, 31) == 0);
         tick(v, {$urandom, $urandom}, r);
         check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
